// File: rtl/uart_rs232.sv
// uart_rs232 - full-duplex 8N1 serial transceiver between the host PC and the
// accelerator's memory I/O stage (file-index bytes, picture/weight bytes).
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per serial bit (50 MHz / 9600 baud = 5208), >= 8
//   CNT_W        - width of the bit-period counters, 2**CNT_W > CLKS_PER_BIT
//
// Ports:
//   clk        - system clock, everything on its rising edge
//   rst        - synchronous active-low reset
//   rx         - asynchronous serial input, idles high
//   tx         - serial output, idles high
//   txdata     - byte to send, sampled only when a request is accepted
//   txdata_en  - send request, accepted when tx_busy is low
//   tx_busy    - high while a frame is being serialised
//   rxdata     - last correctly framed received byte
//   rxdata_rdy - one-cycle strobe, rxdata valid in the same cycle
//   frame_err  - one-cycle strobe when the stop bit samples low
module uart_rs232 #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic [7:0] txdata,
    input  logic       txdata_en,
    output logic       tx_busy,
    output logic [7:0] rxdata,
    output logic       rxdata_rdy,
    output logic       frame_err
);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAITHI} rx_state_t;

    tx_state_t        tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_idx;
    logic [7:0]       tx_shift;

    rx_state_t        rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_idx;
    logic [7:0]       rx_shift;
    logic             rx_meta;
    logic             rx_s;

    // Transmit FSM. tx and tx_busy are registered and are updated one step
    // ahead of the state change, so the start bit appears on the cycle after
    // the request edge and tx_busy drops exactly when the stop bit ends.
    // Requests are only looked at in T_IDLE, so anything arriving mid-frame
    // is dropped and txdata is never resampled during a frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state <= T_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            case (tx_state)
                T_IDLE: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    if (txdata_en) begin
                        tx_shift <= txdata;
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        tx       <= 1'b0;
                        tx_busy  <= 1'b1;
                        tx_state <= T_START;
                    end
                end
                T_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx       <= tx_shift[0];
                        tx_state <= T_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                T_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == 3'd7) begin
                            tx       <= 1'b1;
                            tx_state <= T_STOP;
                        end else begin
                            // tx is registered, so present the next bit
                            // (shift[1]) while the register shifts.
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx       <= tx_shift[1];
                            tx_idx   <= tx_idx + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                T_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx       <= 1'b1;
                        tx_busy  <= 1'b0;
                        tx_state <= T_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                default: begin
                    tx       <= 1'b1;
                    tx_busy  <= 1'b0;
                    tx_state <= T_IDLE;
                end
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous rx line. Both flops reset to
    // the idle level so leaving reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM. After confirming the start bit at its midpoint, every
    // later sample is a whole bit period apart, so all data bits and the stop
    // bit are taken near their centres. A low stop bit parks the FSM in
    // R_WAITHI until the line returns high, so a stuck-low line cannot be
    // mistaken for a stream of new start bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state   <= R_IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            rxdata     <= 8'h00;
            rxdata_rdy <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rxdata_rdy <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    if (!rx_s) begin
                        rx_cnt   <= '0;
                        rx_state <= R_START;
                    end
                end
                R_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_state <= rx_s ? R_IDLE : R_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                R_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        // LSB arrives first, so shifting in at the MSB leaves
                        // the byte correctly ordered after eight samples.
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        if (rx_idx == 3'd7) begin
                            rx_state <= R_STOP;
                        end else begin
                            rx_idx <= rx_idx + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                R_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        if (rx_s) begin
                            rxdata     <= rx_shift;
                            rxdata_rdy <= 1'b1;
                            rx_state   <= R_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            rx_state  <= R_WAITHI;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                R_WAITHI: begin
                    if (rx_s) begin
                        rx_state <= R_IDLE;
                    end
                end
                default: begin
                    rx_state <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rs232.md
# uart_rs232

Full-duplex 8N1 serial transceiver that links the host PC to the accelerator's memory I/O stage. The memory I/O stage exchanges file-index bytes and picture/weight bytes with the host through this block. The receive path turns the asynchronous `rx` line into single-cycle-strobed bytes. The transmit path serialises one byte per request onto `tx` and holds `tx_busy` high while the frame is on the wire.

## Interface
Parameters:
- `CLKS_PER_BIT`, 5208: clock cycles per serial bit (50 MHz / 9600 baud). Minimum 8. Simulation uses 16.
- `CNT_W`, 16: width of the bit-period counters. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- `clk` in 1: single system clock. Everything is synchronous to its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `rx` in 1: asynchronous serial input. Idles high.
- `tx` out 1: serial output. Idles high.
- `txdata` in 8: byte to transmit. Sampled only on an accepted request.
- `txdata_en` in 1: transmit request. Accepted when high on a cycle where `tx_busy`=0.
- `tx_busy` out 1: high while a frame is being serialised.
- `rxdata` out 8: last correctly framed received byte. Held until the next good byte.
- `rxdata_rdy` out 1: one-cycle strobe; `rxdata` is valid on the same cycle.
- `frame_err` out 1: one-cycle strobe when the stop bit samples low.

## Operation
Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.

TX FSM states: T_IDLE → T_START → T_DATA → T_STOP → T_IDLE.
- T_IDLE:
  - `tx`=1, `tx_busy`=0.
  - On `txdata_en`=1, latch `txdata` into the shift register, clear the bit counter, set `tx_busy`=1 and go to T_START.
- T_START: `tx`=0 for CLKS_PER_BIT cycles.
- T_DATA:
  - `tx`=shift[0] for CLKS_PER_BIT cycles per bit.
  - Shift right and increment the 3-bit index; move to T_STOP after index 7.
- T_STOP: `tx`=1 for CLKS_PER_BIT cycles, then go to T_IDLE with `tx_busy`=0.
- `txdata_en` while `tx_busy`=1 is ignored. It is neither queued nor allowed to corrupt the frame in flight.
- `txdata` changing mid-frame has no effect.

RX path: `rx` passes through a 2-flop synchroniser. Call the synchronised signal `rx_s`; the FSM uses only `rx_s`.

RX FSM states: R_IDLE → R_START → R_DATA → R_STOP → R_IDLE, plus R_WAITHI.
- R_IDLE: on `rx_s`=0, clear the counter and go to R_START.
- R_START:
  - After CLKS_PER_BIT/2 cycles (integer division), resample `rx_s`.
  - If 0, go to R_DATA with the counter cleared.
  - If 1, treat it as a glitch: return to R_IDLE with no strobe.
- R_DATA:
  - Sample `rx_s` every CLKS_PER_BIT cycles, which lands at bit centre.
  - Shift the sample into the MSB of the shift register. After 8 samples the register holds the byte LSB-correct.
  - Go to R_STOP.
- R_STOP: after CLKS_PER_BIT cycles, sample `rx_s`.
  - If 1: load `rxdata` from the shift register, pulse `rxdata_rdy` and go to R_IDLE.
  - If 0: pulse `frame_err`, leave `rxdata` unchanged and go to R_WAITHI.
- R_WAITHI: wait for `rx_s`=1, then go to R_IDLE. This prevents a stuck-low line from retriggering frames.

TX and RX are fully independent and may operate simultaneously.

Reset (`rst`=0 on a clock edge):
- Both FSMs return to idle.
- `tx`=1, `tx_busy`=0, `rxdata`=8'h00, `rxdata_rdy`=0, `frame_err`=0.
- Synchroniser flops are set to 1.
- Reset mid-frame aborts the frame immediately: `tx` returns high on the next cycle and no strobe is produced.

## Timing
- TX acceptance: request seen at edge N. `tx_busy`=1 and `tx`=0 (start bit) from cycle N+1.
- TX frame length: exactly 10·CLKS_PER_BIT cycles from N+1. `tx_busy` falls at N+1+10·CLKS_PER_BIT.
- TX back-to-back: a request asserted on the first cycle `tx_busy`=0 is accepted. The next start bit follows the previous stop bit with at most 1 cycle of extra idle.
- `tx_busy` is registered. There is no combinational path from `txdata_en` to `tx_busy`.
- RX latency: `rxdata_rdy` pulses 2 (synchroniser) + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the `rx` falling edge, ±1 cycle.
- Strobe width: `rxdata_rdy` and `frame_err` are each exactly 1 cycle wide and never asserted together.
- Back-to-back RX: a new start bit may follow the stop-bit sample immediately. Sampling at the stop-bit centre leaves half a bit of margin.
- Baud tolerance: with mid-bit sampling, RX must accept ±3% baud mismatch.

## Test plan
All scenarios use CLKS_PER_BIT=16.
- Reset: hold `rst`=0 for 3 cycles with `rx`=1 → `tx`=1, `tx_busy`=0, `rxdata`=00, no strobes.
- TX single byte: `txdata`=8'h52 ('R') with a 1-cycle `txdata_en` → `tx` bit sequence 0,0,1,0,0,1,0,1,0,1, each bit 16 cycles; `tx_busy` high for exactly 160 cycles.
- TX busy request: assert `txdata_en` with `txdata`=8'hFF at cycle 40 of a frame carrying 8'h57 → frame still carries 57; no second frame starts.
- RX good bytes: drive 8'hA5, then 8'h00, back-to-back from a model with CLKS_PER_BIT=16 → `rxdata_rdy` pulses twice, `rxdata`=A5 then 00, `frame_err` never asserted.
- RX framing error: drive 8'h3C with stop bit 0, hold low 40 cycles, then high, then a good 8'h81 → one `frame_err` pulse, `rxdata` stays at its previous value, a single `rxdata_rdy` with `rxdata`=81.
- RX glitch and mid-frame reset:
  - Drive a 4-cycle low pulse on `rx` → no strobe and FSM back to idle.
  - Assert `rst` during TX data bit 3 → `tx`=1 and `tx_busy`=0 the next cycle; a new request afterwards sends a clean frame.
